// File: rtl/qx1_operand_fetch_pkg.sv
// qx1_operand_fetch_pkg: shared QX1 operand-fetch defaults; QX1_OPF_BYPASS_EN enables writeback forwarding.
package qx1_operand_fetch_pkg;
  localparam int QX1_DATA_W = 16;
  localparam int QX1_ADDR_W = 3;
  localparam int QX1_NREGS  = 8;
  localparam int QX1_CTRL_W = 8;
`ifdef QX1_OPF_BYPASS_EN
  localparam bit QX1_BYPASS = 1'b1;
`else
  localparam bit QX1_BYPASS = 1'b0;
`endif
endpackage

// File: rtl/qx1_operand_fetch_scoreboard.sv
// qx1_operand_fetch_scoreboard: in-flight destination bits with set-wins-over-clear and two busy lookups.
module qx1_operand_fetch_scoreboard #(
  parameter int ADDR_W = 3,
  parameter int NREGS  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_i,
  input  logic [ADDR_W-1:0] set_idx_i,
  input  logic              clr_i,
  input  logic [ADDR_W-1:0] clr_idx_i,
  input  logic [ADDR_W-1:0] rd1_idx_i,
  input  logic [ADDR_W-1:0] rd2_idx_i,
  output logic              busy1_o,
  output logic              busy2_o
);
  logic [NREGS-1:0] sb_q, sb_d, set_m, clr_m;
  always_comb begin
    set_m = '0;
    clr_m = '0;
    set_m[set_idx_i] = set_i;
    clr_m[clr_idx_i] = clr_i;
    sb_d = (sb_q & ~clr_m) | set_m;
  end
  always_ff @(posedge clk) sb_q <= rst ? '0 : sb_d;
  assign busy1_o = sb_q[rd1_idx_i];
  assign busy2_o = sb_q[rd2_idx_i];
endmodule

// File: rtl/qx1_operand_fetch.sv
// qx1_operand_fetch: operand-fetch stage with RAW scoreboard stall and optional writeback forwarding.
module qx1_operand_fetch
  import qx1_operand_fetch_pkg::*;
#(
  parameter int DATA_W = QX1_DATA_W,
  parameter int ADDR_W = QX1_ADDR_W,
  parameter int NREGS  = QX1_NREGS,
  parameter int CTRL_W = QX1_CTRL_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_rs1,
  input  logic [ADDR_W-1:0] in_rs2,
  input  logic              in_rs1_use,
  input  logic              in_rs2_use,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic              in_rd_we,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic [ADDR_W-1:0] rf_read_addr1,
  output logic [ADDR_W-1:0] rf_read_addr2,
  input  logic [DATA_W-1:0] rf_read_data1,
  input  logic [DATA_W-1:0] rf_read_data2,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_dest,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_op_a,
  output logic [DATA_W-1:0] out_op_b,
  output logic [ADDR_W-1:0] out_rd,
  output logic              out_rd_we,
  output logic [CTRL_W-1:0] out_ctrl
);
  logic              valid_q, valid_d, rd_we_q, rd_we_d;
  logic [DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic busy1, busy2, wb1, wb2, pend1, pend2, hz1, hz2, free, accept;
  qx1_operand_fetch_scoreboard #(.ADDR_W(ADDR_W), .NREGS(NREGS)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_i    (valid_q && out_ready && rd_we_q),
    .set_idx_i(rd_q),
    .clr_i    (wb_en),
    .clr_idx_i(wb_dest),
    .rd1_idx_i(in_rs1),
    .rd2_idx_i(in_rs2),
    .busy1_o  (busy1),
    .busy2_o  (busy2)
  );
  assign rf_read_addr1 = in_rs1;
  assign rf_read_addr2 = in_rs2;
  assign wb1 = wb_en && wb_dest == in_rs1;
  assign wb2 = wb_en && wb_dest == in_rs2;
  // With forwarding a same-cycle writeback resolves the pending bit; without it the write must land first
  assign pend1 = QX1_BYPASS ? busy1 && !wb1 : busy1 || wb1;
  assign pend2 = QX1_BYPASS ? busy2 && !wb2 : busy2 || wb2;
  assign hz1 = in_rs1_use && (pend1 || (valid_q && rd_we_q && rd_q == in_rs1));
  assign hz2 = in_rs2_use && (pend2 || (valid_q && rd_we_q && rd_q == in_rs2));
  assign free = !valid_q || out_ready;
  assign in_ready = !rst && !flush && free && !hz1 && !hz2;
  assign accept = in_valid && in_ready;
  always_comb begin
    valid_d = accept ? 1'b1 : (flush || out_ready) ? 1'b0 : valid_q;
    op_a_d  = accept ? ((QX1_BYPASS && wb1) ? wb_data : rf_read_data1) : op_a_q;
    op_b_d  = accept ? ((QX1_BYPASS && wb2) ? wb_data : rf_read_data2) : op_b_q;
    rd_d    = accept ? in_rd : rd_q;
    rd_we_d = accept ? in_rd_we : rd_we_q;
    ctrl_d  = accept ? in_ctrl : ctrl_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      rd_q    <= '0;
      rd_we_q <= 1'b0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      rd_q    <= rd_d;
      rd_we_q <= rd_we_d;
      ctrl_q  <= ctrl_d;
    end
  end
  assign out_valid = valid_q;
  assign out_op_a  = op_a_q;
  assign out_op_b  = op_b_q;
  assign out_rd    = rd_q;
  assign out_rd_we = rd_we_q;
  assign out_ctrl  = ctrl_q;
endmodule

// File: tb/tb_qx1_operand_fetch.sv
// tb_qx1_operand_fetch: directed scenarios then random traffic against a rule-level model of the stage.
module tb_qx1_operand_fetch;
  import qx1_operand_fetch_pkg::*;
  logic        clk = 1'b0, rst, in_valid, in_ready, in_rs1_use, in_rs2_use, in_rd_we;
  logic [2:0]  in_rs1, in_rs2, in_rd, rf_read_addr1, rf_read_addr2, wb_dest, out_rd;
  logic [7:0]  in_ctrl, out_ctrl;
  logic [15:0] rf_read_data1, rf_read_data2, wb_data, out_op_a, out_op_b;
  logic        wb_en, flush, out_valid, out_ready, out_rd_we;
  logic [15:0] regs [8];
  logic        m_ov = 1'b0, m_we = 1'b0;
  logic [15:0] m_a = '0, m_b = '0;
  logic [2:0]  m_rd = '0;
  logic [7:0]  m_ctrl = '0, m_sb = '0;
  logic [2:0]  wbq [$];
  bit          pop_wb;
  logic        obs_rdy;
  int          n_chk = 0, n_fail = 0, lat;
  qx1_operand_fetch dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs1_use(in_rs1_use), .in_rs2_use(in_rs2_use),
    .in_rd(in_rd), .in_rd_we(in_rd_we), .in_ctrl(in_ctrl),
    .rf_read_addr1(rf_read_addr1), .rf_read_addr2(rf_read_addr2),
    .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
    .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_op_a(out_op_a), .out_op_b(out_op_b),
    .out_rd(out_rd), .out_rd_we(out_rd_we), .out_ctrl(out_ctrl)
  );
  always #5 clk = ~clk;
  assign rf_read_data1 = regs[rf_read_addr1];
  assign rf_read_data2 = regs[rf_read_addr2];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // A source is pending while any older writer of it has not yet written the register file
  function automatic bit pend(input logic [2:0] r);
    bit hit;
    hit = wb_en && wb_dest == r;
    return (m_sb[r] && !(QX1_BYPASS && hit)) || (m_ov && m_we && m_rd == r) || (!QX1_BYPASS && hit);
  endfunction
  task automatic step();
    logic er, acc;
    logic [15:0] fa, fb;
    #1;
    er = !rst && !flush && (!m_ov || out_ready) && !(in_rs1_use && pend(in_rs1)) && !(in_rs2_use && pend(in_rs2));
    obs_rdy = in_ready;
    chk("in_ready", 32'(in_ready), 32'(er));
    chk("rf_addr1", 32'(rf_read_addr1), 32'(in_rs1));
    chk("rf_addr2", 32'(rf_read_addr2), 32'(in_rs2));
    acc = in_valid && er;
    fa = (QX1_BYPASS && wb_en && wb_dest == in_rs1) ? wb_data : regs[in_rs1];
    fb = (QX1_BYPASS && wb_en && wb_dest == in_rs2) ? wb_data : regs[in_rs2];
    @(posedge clk);
    #1;
    if (rst) begin
      m_ov = 0; m_a = 0; m_b = 0; m_rd = 0; m_we = 0; m_ctrl = 0; m_sb = 0;
      wbq.delete();
    end else begin
      if (pop_wb && wbq.size() != 0) void'(wbq.pop_front());
      if (m_ov && out_ready && m_we) wbq.push_back(m_rd);
      if (wb_en) m_sb[wb_dest] = 1'b0;
      if (m_ov && out_ready && m_we) m_sb[m_rd] = 1'b1;
      if (acc) begin
        m_ov = 1; m_a = fa; m_b = fb; m_rd = in_rd; m_we = in_rd_we; m_ctrl = in_ctrl;
      end else if (flush || out_ready) m_ov = 0;
    end
    if (wb_en) regs[wb_dest] = wb_data;
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("sb", 32'(dut.u_sb.sb_q), 32'(m_sb));
    if (m_ov) begin
      chk("out_op_a", 32'(out_op_a), 32'(m_a));
      chk("out_op_b", 32'(out_op_b), 32'(m_b));
      chk("out_rd", 32'(out_rd), 32'(m_rd));
      chk("out_rd_we", 32'(out_rd_we), 32'(m_we));
      chk("out_ctrl", 32'(out_ctrl), 32'(m_ctrl));
    end
    @(negedge clk);
  endtask
  task automatic issue(input logic [2:0] rs1, rs2, rd, input logic u1, u2, we);
    in_valid = 1; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
    in_rs1_use = u1; in_rs2_use = u2; in_rd_we = we; in_ctrl = 8'($urandom);
  endtask
  task automatic rnd();
    in_valid = ($urandom % 4) != 0;
    in_rs1 = 3'($urandom); in_rs2 = 3'($urandom); in_rd = 3'($urandom);
    in_rs1_use = ($urandom % 4) != 0; in_rs2_use = ($urandom % 4) != 0;
    in_rd_we = ($urandom % 4) != 0; in_ctrl = 8'($urandom);
    out_ready = ($urandom % 4) != 0;
    flush = ($urandom % 20) == 0;
    pop_wb = 0; wb_en = 0; wb_dest = 0; wb_data = 16'($urandom);
    if (wbq.size() != 0 && ($urandom % 2) == 1) begin
      wb_en = 1; wb_dest = wbq[0]; pop_wb = 1;
    end else if (($urandom % 16) == 0) begin
      wb_en = 1; wb_dest = 3'($urandom);
    end
  endtask
  initial begin
    for (int i = 0; i < 8; i++) regs[i] = '0;
    regs[1] = 16'd5; regs[2] = 16'd7;
    rst = 1; in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rs1_use = 0; in_rs2_use = 0;
    in_rd = 0; in_rd_we = 0; in_ctrl = 0; wb_en = 0; wb_dest = 0; wb_data = 0;
    flush = 0; out_ready = 1; pop_wb = 0;
    @(negedge clk);
    step(); step();
    chk("rst_rdy", 32'(obs_rdy), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_op_a", 32'(out_op_a), 0);
    chk("rst_op_b", 32'(out_op_b), 0);
    chk("rst_rd", 32'(out_rd), 0);
    chk("rst_ctrl", 32'({out_rd_we, out_ctrl}), 0);
    chk("rst_sb", 32'(dut.u_sb.sb_q), 0);
    rst = 0;
    step();
    chk("post_rst_rdy", 32'(obs_rdy), 1);
    issue(3'd1, 3'd2, 3'd3, 1, 1, 1);
    step();
    chk("t2_a", 32'(out_op_a), 5);
    chk("t2_b", 32'(out_op_b), 7);
    chk("t2_rd", 32'(out_rd), 3);
    issue(3'd3, 3'd0, 3'd5, 1, 0, 0);
    step();
    chk("t3_stall_out", 32'(obs_rdy), 0);
    step();
    chk("t3_stall_sb", 32'(obs_rdy), 0);
    wb_en = 1; wb_dest = 3'd3; wb_data = 16'h00AA;
    step();
    wb_en = 0;
    lat = 0;
    while (!obs_rdy && lat < 4) begin
      lat++;
      step();
    end
    in_valid = 0;
    chk("t3_lat", lat, QX1_BYPASS ? 0 : 1);
    chk("t3_a", 32'(out_op_a), 32'h00AA);
    out_ready = 0;
    issue(3'd1, 3'd2, 3'd6, 1, 1, 1);
    repeat (3) begin
      step();
      chk("t4_hold_a", 32'(out_op_a), 32'h00AA);
      chk("t4_hold_rd", 32'(out_rd), 5);
      chk("t4_rdy", 32'(obs_rdy), 0);
    end
    out_ready = 1; in_valid = 0;
    step();
    chk("t4_single", 32'(out_valid), 0);
    out_ready = 0;
    issue(3'd1, 3'd2, 3'd4, 1, 1, 1);
    step();
    chk("t5_loaded", 32'(out_valid), 1);
    flush = 1;
    issue(3'd2, 3'd1, 3'd6, 1, 1, 1);
    step();
    flush = 0; in_valid = 0;
    chk("t5_rdy", 32'(obs_rdy), 0);
    chk("t5_valid", 32'(out_valid), 0);
    chk("t5_sb4", 32'(dut.u_sb.sb_q[4]), 0);
    issue(3'd1, 3'd2, 3'd4, 1, 1, 1);
    step();
    in_valid = 0; out_ready = 1; wb_en = 1; wb_dest = 3'd4; wb_data = 16'h1234;
    step();
    chk("t6_sb4", 32'(dut.u_sb.sb_q[4]), 1);
    wb_en = 0;
    issue(3'd4, 3'd0, 3'd0, 1, 0, 0);
    step();
    chk("t6_stall", 32'(obs_rdy), 0);
    in_valid = 0; wb_en = 1;
    step();
    wb_en = 0;
    wbq.delete();
    for (int i = 0; i < 3000; i++) begin
      rnd();
      rst = (i == 1500);
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
